conv_pingpong_bram: RTL and testbench

CONV_PINGPONG_BRAM -- requirements
Module: conv_pingpong_bram

---
 rtl/conv_pingpong_bram.sv | 187 ++++++++++++++++++
 tb/tb_conv_pingpong_bram.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pingpong_bram.sv
// conv_pingpong_bram
//   Ping-pong buffer built from one 2*DEPTH-word RAM split into two banks.
//   The producer fills the write bank through port A and commits it; the
//   consumer reads the other bank through port B and releases it. The banks
//   swap roles once the write bank is full and the read bank is empty.
//
// Parameters
//   DATA_W  word width in bits (multiple of 8)
//   DEPTH   words per bank (power of 2, >= 4)
//   OUT_REG 1 adds an output register stage on port B, 0 removes it
//
// Optional feature
//   CONV_BRAM_PARITY_EN  when defined, one even-parity bit is stored per byte
//                        and BRAM_PORTB_0_perr flags a mismatch on read;
//                        otherwise no parity is stored and perr stays 0.
//
// Ports
//   BRAM_0_clk / BRAM_0_rst   clock, asynchronous active-high reset
//   BRAM_PORTA_0_*            write side: addr, din, en, we (per byte),
//                             commit pulse, ready (write bank not full)
//   BRAM_PORTB_0_*            read side: addr, en, release pulse, ready
//                             (read bank holds committed data), dout,
//                             valid, perr
//   wr_bank                   current write bank; read bank is its inverse
module conv_pingpong_bram #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int OUT_REG = 1
) (
   input  logic                      BRAM_0_clk,
   input  logic                      BRAM_0_rst,
   input  logic [$clog2(DEPTH)-1:0]  BRAM_PORTA_0_addr,
   input  logic [DATA_W-1:0]         BRAM_PORTA_0_din,
   input  logic                      BRAM_PORTA_0_en,
   input  logic [DATA_W/8-1:0]       BRAM_PORTA_0_we,
   input  logic                      BRAM_PORTA_0_commit,
   output logic                      BRAM_PORTA_0_ready,
   input  logic [$clog2(DEPTH)-1:0]  BRAM_PORTB_0_addr,
   input  logic                      BRAM_PORTB_0_en,
   input  logic                      BRAM_PORTB_0_release,
   output logic                      BRAM_PORTB_0_ready,
   output logic [DATA_W-1:0]         BRAM_PORTB_0_dout,
   output logic                      BRAM_PORTB_0_valid,
   output logic                      BRAM_PORTB_0_perr,
   output logic                      wr_bank
);

   localparam int AW = $clog2(DEPTH);
   localparam int NB = DATA_W / 8;

   logic              wr_bank_q;
   logic [1:0]        full_q;
   logic              porta_ready;
   logic              portb_ready;
   logic              wr_acc;
   logic              rd_acc;
   logic [AW:0]       wr_phys;
   logic [AW:0]       rd_phys;
   logic [DATA_W-1:0] rd_word;
   logic              rd_bad;

   logic [DATA_W-1:0] mem [2*DEPTH];

`ifdef CONV_BRAM_PARITY_EN
   logic [NB-1:0]     par_mem [2*DEPTH];

   // Even parity: stored bit equals the XOR of the byte, so byte^bit is 0
   // for an intact byte.
   function automatic logic parity_err(input logic [DATA_W-1:0] word,
                                       input logic [NB-1:0]     par);
      logic err;
      err = 1'b0;
      for (int i = 0; i < NB; i++) begin
         err = err | ((^word[i*8 +: 8]) ^ par[i]);
      end
      return err;
   endfunction
`endif

   assign porta_ready = !full_q[wr_bank_q];
   assign portb_ready = full_q[~wr_bank_q];
   assign wr_acc      = BRAM_PORTA_0_en & porta_ready;
   assign rd_acc      = BRAM_PORTB_0_en & portb_ready;
   assign wr_phys     = {wr_bank_q, BRAM_PORTA_0_addr};
   assign rd_phys     = {~wr_bank_q, BRAM_PORTB_0_addr};

   assign BRAM_PORTA_0_ready = porta_ready;
   assign BRAM_PORTB_0_ready = portb_ready;
   assign wr_bank            = wr_bank_q;

   // Bank control. A commit can only land while the write bank is empty and
   // a release only while the read bank is full, so neither can coincide
   // with a swap edge; the swap is decided from the registered flags alone.
   always_ff @(posedge BRAM_0_clk or posedge BRAM_0_rst) begin
      if (BRAM_0_rst) begin
         wr_bank_q <= 1'b0;
         full_q    <= 2'b00;
      end else begin
         if (BRAM_PORTA_0_commit && porta_ready) full_q[wr_bank_q]  <= 1'b1;
         if (BRAM_PORTB_0_release && portb_ready) full_q[~wr_bank_q] <= 1'b0;
         if (full_q[wr_bank_q] && !full_q[~wr_bank_q]) wr_bank_q <= ~wr_bank_q;
      end
   end

   // Port A byte writes; storage is never reset.
   always_ff @(posedge BRAM_0_clk) begin
      if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (BRAM_PORTA_0_we[i]) begin
               mem[wr_phys][i*8 +: 8] <= BRAM_PORTA_0_din[i*8 +: 8];
`ifdef CONV_BRAM_PARITY_EN
               par_mem[wr_phys][i]    <= ^BRAM_PORTA_0_din[i*8 +: 8];
`endif
            end
         end
      end
   end

   // The array is sampled at the accept edge, so a read accepted just before
   // a swap always returns the pre-swap bank contents.
   assign rd_word = mem[rd_phys];
`ifdef CONV_BRAM_PARITY_EN
   assign rd_bad  = parity_err(rd_word, par_mem[rd_phys]);
`else
   assign rd_bad  = 1'b0;
`endif

   logic [DATA_W-1:0] dout_p2;
   logic              perr_p2;
   logic              vld_p2;

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] data_p1;
         logic              bad_p1;
         logic              vld_p1;

         // ---- stage p1: RAM read register
         always_ff @(posedge BRAM_0_clk) begin
            if (rd_acc) begin
               data_p1 <= rd_word;
               bad_p1  <= rd_bad;
            end
         end

         always_ff @(posedge BRAM_0_clk or posedge BRAM_0_rst) begin
            if (BRAM_0_rst) vld_p1 <= 1'b0;
            else            vld_p1 <= rd_acc;
         end

         // ---- stage p2: output register, holds while no read retires
         always_ff @(posedge BRAM_0_clk or posedge BRAM_0_rst) begin
            if (BRAM_0_rst) begin
               vld_p2  <= 1'b0;
               dout_p2 <= '0;
               perr_p2 <= 1'b0;
            end else begin
               vld_p2 <= vld_p1;
               if (vld_p1) begin
                  dout_p2 <= data_p1;
                  perr_p2 <= bad_p1;
               end
            end
         end
      end else begin : g_no_out_reg
         // ---- stage p1 doubles as the output stage
         always_ff @(posedge BRAM_0_clk or posedge BRAM_0_rst) begin
            if (BRAM_0_rst) begin
               vld_p2  <= 1'b0;
               dout_p2 <= '0;
               perr_p2 <= 1'b0;
            end else begin
               vld_p2 <= rd_acc;
               if (rd_acc) begin
                  dout_p2 <= rd_word;
                  perr_p2 <= rd_bad;
               end
            end
         end
      end
   endgenerate

   assign BRAM_PORTB_0_dout  = dout_p2;
   assign BRAM_PORTB_0_valid = vld_p2;
   assign BRAM_PORTB_0_perr  = perr_p2;

endmodule

// File: tb/tb_conv_pingpong_bram.sv
// Testbench for conv_pingpong_bram: directed scenarios plus randomized
// traffic, all checked against a bank-level reference model.
module tb_conv_pingpong_bram;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 16;
   localparam int OUT_REG = 1;
   localparam int AW      = 4;
   localparam int NB      = 4;

   logic              BRAM_0_clk = 1'b0;
   logic              BRAM_0_rst = 1'b0;
   logic [AW-1:0]     BRAM_PORTA_0_addr;
   logic [DATA_W-1:0] BRAM_PORTA_0_din;
   logic              BRAM_PORTA_0_en;
   logic [NB-1:0]     BRAM_PORTA_0_we;
   logic              BRAM_PORTA_0_commit;
   logic              BRAM_PORTA_0_ready;
   logic [AW-1:0]     BRAM_PORTB_0_addr;
   logic              BRAM_PORTB_0_en;
   logic              BRAM_PORTB_0_release;
   logic              BRAM_PORTB_0_ready;
   logic [DATA_W-1:0] BRAM_PORTB_0_dout;
   logic              BRAM_PORTB_0_valid;
   logic              BRAM_PORTB_0_perr;
   logic              wr_bank;

   conv_pingpong_bram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_REG(OUT_REG)) dut (
      .BRAM_0_clk           (BRAM_0_clk),
      .BRAM_0_rst           (BRAM_0_rst),
      .BRAM_PORTA_0_addr    (BRAM_PORTA_0_addr),
      .BRAM_PORTA_0_din     (BRAM_PORTA_0_din),
      .BRAM_PORTA_0_en      (BRAM_PORTA_0_en),
      .BRAM_PORTA_0_we      (BRAM_PORTA_0_we),
      .BRAM_PORTA_0_commit  (BRAM_PORTA_0_commit),
      .BRAM_PORTA_0_ready   (BRAM_PORTA_0_ready),
      .BRAM_PORTB_0_addr    (BRAM_PORTB_0_addr),
      .BRAM_PORTB_0_en      (BRAM_PORTB_0_en),
      .BRAM_PORTB_0_release (BRAM_PORTB_0_release),
      .BRAM_PORTB_0_ready   (BRAM_PORTB_0_ready),
      .BRAM_PORTB_0_dout    (BRAM_PORTB_0_dout),
      .BRAM_PORTB_0_valid   (BRAM_PORTB_0_valid),
      .BRAM_PORTB_0_perr    (BRAM_PORTB_0_perr),
      .wr_bank              (wr_bank)
   );

   always #5 BRAM_0_clk = ~BRAM_0_clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: two banks of words, a full flag per bank, the write
   // bank index, and a list of reads waiting to retire.
   logic [DATA_W-1:0] m_mem [2][DEPTH];
   bit                m_bad [2][DEPTH];
   bit                m_full [2];
   bit                m_wb;
   logic [DATA_W-1:0] m_dout;
   bit                m_perr;
   int                edge_n = 0;

   typedef struct {int due; logic [DATA_W-1:0] data; bit bad;} rd_t;
   rd_t pend[$];

   typedef struct {int e; logic [DATA_W-1:0] d; bit p;} obs_t;
   obs_t obs[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      BRAM_PORTA_0_addr    = '0;
      BRAM_PORTA_0_din     = '0;
      BRAM_PORTA_0_en      = 1'b0;
      BRAM_PORTA_0_we      = '0;
      BRAM_PORTA_0_commit  = 1'b0;
      BRAM_PORTB_0_addr    = '0;
      BRAM_PORTB_0_en      = 1'b0;
      BRAM_PORTB_0_release = 1'b0;
   endtask

   // One clock cycle: check the ready/bank outputs, advance the model with
   // the inputs currently driven, clock, then check the read outputs.
   task automatic step();
      bit   ra, rb, sw, exp_v;
      rd_t  r;
      obs_t o;
      ra = !m_full[m_wb];
      rb = m_full[!m_wb];
      check("a_ready", BRAM_PORTA_0_ready, ra);
      check("b_ready", BRAM_PORTB_0_ready, rb);
      check("wr_bank", wr_bank, m_wb);
      if (BRAM_PORTA_0_en && ra) begin
         for (int i = 0; i < NB; i++) begin
            if (BRAM_PORTA_0_we[i]) begin
               m_mem[m_wb][BRAM_PORTA_0_addr][i*8 +: 8] = BRAM_PORTA_0_din[i*8 +: 8];
               if (i == 0) m_bad[m_wb][BRAM_PORTA_0_addr] = 1'b0;
            end
         end
      end
      if (BRAM_PORTB_0_en && rb) begin
         // accepted at the coming edge; retires OUT_REG edges after it
         r.due  = edge_n + 1 + OUT_REG;
         r.data = m_mem[!m_wb][BRAM_PORTB_0_addr];
         r.bad  = m_bad[!m_wb][BRAM_PORTB_0_addr];
         pend.push_back(r);
      end
      sw = m_full[m_wb] && !m_full[!m_wb];
      if (BRAM_PORTA_0_commit && ra)  m_full[m_wb]  = 1'b1;
      if (BRAM_PORTB_0_release && rb) m_full[!m_wb] = 1'b0;
      if (sw) m_wb = !m_wb;
      @(posedge BRAM_0_clk);
      edge_n++;
      #1;
      exp_v = (pend.size() > 0) && (pend[0].due == edge_n);
      if (exp_v) begin
         m_dout = pend[0].data;
         m_perr = pend[0].bad;
         void'(pend.pop_front());
      end
      check("valid", BRAM_PORTB_0_valid, exp_v);
      check("dout", BRAM_PORTB_0_dout, m_dout);
      check("perr", BRAM_PORTB_0_perr, m_perr);
      if (BRAM_PORTB_0_valid) begin
         o.e = edge_n;
         o.d = BRAM_PORTB_0_dout;
         o.p = BRAM_PORTB_0_perr;
         obs.push_back(o);
      end
   endtask

   task automatic write_word(input int a, input logic [DATA_W-1:0] d, input logic [NB-1:0] we);
      idle();
      BRAM_PORTA_0_en   = 1'b1;
      BRAM_PORTA_0_addr = AW'(a);
      BRAM_PORTA_0_din  = d;
      BRAM_PORTA_0_we   = we;
      step();
   endtask

   task automatic read_word(input int a);
      idle();
      BRAM_PORTB_0_en   = 1'b1;
      BRAM_PORTB_0_addr = AW'(a);
      step();
   endtask

   task automatic pulse(input bit commit, input bit rel);
      idle();
      BRAM_PORTA_0_commit  = commit;
      BRAM_PORTB_0_release = rel;
      step();
   endtask

   // Assert reset mid-cycle, check the asynchronous effect, hold for two
   // edges and release it just after an edge.
   task automatic do_reset();
      idle();
      #2 BRAM_0_rst = 1'b1;
      #1;
      pend.delete();
      m_wb      = 1'b0;
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      m_dout    = '0;
      m_perr    = 1'b0;
      check("rst_valid", BRAM_PORTB_0_valid, 0);
      check("rst_dout", BRAM_PORTB_0_dout, 0);
      check("rst_perr", BRAM_PORTB_0_perr, 0);
      check("rst_a_ready", BRAM_PORTA_0_ready, 1);
      check("rst_b_ready", BRAM_PORTB_0_ready, 0);
      check("rst_wr_bank", wr_bank, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge BRAM_0_clk);
         edge_n++;
         #1;
         check("rst_hold_valid", BRAM_PORTB_0_valid, 0);
      end
      BRAM_0_rst = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] rnd;
      int                guard;
      idle();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < DEPTH; a++) begin
            m_mem[b][a] = '0;
            m_bad[b][a] = 1'b0;
         end
      do_reset();

      // Single word round trip through a bank swap.
      idle();
      BRAM_PORTA_0_en     = 1'b1;
      BRAM_PORTA_0_addr   = 4'd3;
      BRAM_PORTA_0_din    = 32'hA5A5A5A5;
      BRAM_PORTA_0_we     = 4'hF;
      BRAM_PORTA_0_commit = 1'b1;
      step();
      pulse(0, 0);
      check("swap_b_ready", BRAM_PORTB_0_ready, 1);
      check("swap_wr_bank", wr_bank, 1);
      obs.delete();
      read_word(3);
      pulse(0, 0);
      pulse(0, 0);
      check("rd3_count", obs.size(), 1);
      if (obs.size() == 1) begin
         check("rd3_data", obs[0].d, 32'hA5A5A5A5);
         check("rd3_latency", obs[0].e, edge_n - 1);
      end

      // Byte-enable merge, then fill the rest of bank 1 and commit it.
      write_word(5, 32'h11223344, 4'hF);
      write_word(5, 32'hFFFFFFFF, 4'b0010);
      for (int a = 0; a < DEPTH; a++)
         if (a != 5) write_word(a, $urandom, 4'hF);
      pulse(1, 0);
      check("both_full_a_ready", BRAM_PORTA_0_ready, 0);
      // Dropped write and ignored commit while both banks are full.
      idle();
      BRAM_PORTA_0_en     = 1'b1;
      BRAM_PORTA_0_addr   = 4'd0;
      BRAM_PORTA_0_din    = 32'hDEADBEEF;
      BRAM_PORTA_0_we     = 4'hF;
      BRAM_PORTA_0_commit = 1'b1;
      step();
      pulse(0, 1);
      check("rel_wr_bank_before_swap", wr_bank, 1);
      pulse(0, 0);
      check("rel_wr_bank_after_swap", wr_bank, 0);
      obs.delete();
      read_word(5);
      pulse(0, 0);
      pulse(0, 0);
      check("merge_count", obs.size(), 1);
      if (obs.size() == 1) check("merge_data", obs[0].d, 32'h1122FF44);

      // Back-to-back reads of addresses 0..7.
      obs.delete();
      for (int a = 0; a < 8; a++) read_word(a);
      for (int i = 0; i < 3; i++) pulse(0, 0);
      check("b2b_count", obs.size(), 8);
      if (obs.size() == 8) begin
         check("b2b_span", obs[7].e - obs[0].e, 7);
         for (int a = 0; a < 8; a++) check("b2b_data", obs[a].d, m_mem[1][a]);
         check("b2b_not_dropped_write", obs[0].d == 32'hDEADBEEF, 0);
      end

      // Fill bank 0, commit, release bank 1 so both banks hold known data.
      for (int a = 0; a < DEPTH; a++) write_word(a, $urandom, 4'hF);
      pulse(1, 0);
      pulse(0, 1);
      pulse(0, 0);
      pulse(0, 0);

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         BRAM_PORTA_0_en      = 1'($urandom_range(0, 1));
         BRAM_PORTA_0_addr    = AW'($urandom_range(0, DEPTH - 1));
         BRAM_PORTA_0_din     = $urandom;
         BRAM_PORTA_0_we      = NB'($urandom);
         BRAM_PORTA_0_commit  = ($urandom_range(0, 7) == 0);
         BRAM_PORTB_0_release = ($urandom_range(0, 7) == 0);
         BRAM_PORTB_0_en      = 1'($urandom_range(0, 1));
         BRAM_PORTB_0_addr    = AW'($urandom_range(0, DEPTH - 1));
         step();
      end

      // Reset in the cycle after an accepted read: that read never retires.
      guard = 0;
      while (!m_full[!m_wb] && guard < 20) begin
         pulse(1, 0);
         guard++;
      end
      check("mid_read_ready", BRAM_PORTB_0_ready, 1);
      obs.delete();
      read_word($urandom_range(0, DEPTH - 1));
      do_reset();
      for (int i = 0; i < 4; i++) pulse(0, 0);
      check("mid_read_no_valid", obs.size(), 0);

`ifdef CONV_BRAM_PARITY_EN
      // Corrupt one stored parity bit of bank 0 word 1.
      rnd = $urandom;
      write_word(1, rnd, 4'hF);
      write_word(2, ~rnd, 4'hF);
      pulse(1, 0);
      pulse(0, 0);
      dut.par_mem[1][0] = ~dut.par_mem[1][0];
      m_bad[0][1] = 1'b1;
      obs.delete();
      read_word(1);
      read_word(2);
      pulse(0, 0);
      pulse(0, 0);
      check("par_count", obs.size(), 2);
      if (obs.size() == 2) begin
         check("par_bad_word", obs[0].p, 1);
         check("par_good_word", obs[1].p, 0);
      end
`else
      rnd = '0;
      check("perr_tied", BRAM_PORTB_0_perr | (|rnd), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
